// File: rtl/mux_read_sequencer_if.sv
// mux_read_sequencer_if: control, mux-drive and downstream handshake signals of the read sequencer
interface mux_read_sequencer_if;
  logic       start;
  logic [4:0] phase_en;
  logic [3:0] job_id;
  logic [7:0] sel;
  logic [7:0] s;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  modport master (
    input  start, phase_en, job_id, out_ready,
    output sel, s, out_valid, busy, done
  );
  modport slave (
    output start, phase_en, job_id, out_ready,
    input  sel, s, out_valid, busy, done
  );
endinterface

// File: rtl/mux_read_sequencer.sv
// mux_read_sequencer: sweeps the enabled mux phases, driving sel/s with a registered valid/ready handshake
module mux_read_sequencer #(
  parameter int NUM_PIXEL = 8
) (
  input logic                  clock,
  input logic                  reset,
  mux_read_sequencer_if.master bus
);
  localparam int ROWS_END = NUM_PIXEL + 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t     state;
  logic [4:0] en;
  logic [4:0] rest;
  logic [2:0] phase;
  logic [2:0] nxt_phase;
  logic [2:0] first_phase;
  logic [2:0] step_phase;
  logic [7:0] first_sel;
  logic [7:0] step_sel;
  logic       at_end;
  logic       final_beat;
  logic       issue;
  function automatic logic [7:0] base(input logic [2:0] p);
    return p == 3'd0 ? 8'd0 : 8'(ROWS_END + (int'(p) - 1) * NUM_PIXEL);
  endfunction
  function automatic logic [7:0] lim(input logic [2:0] p);
    return 8'(ROWS_END + int'(p) * NUM_PIXEL);
  endfunction
  function automatic logic [4:0] above(input logic [2:0] p);
    return 5'h1F << (p + 3'd1);
  endfunction
  function automatic logic [2:0] lowest(input logic [4:0] m);
    lowest = 3'd0;
    for (int i = 4; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction
  function automatic logic last_of(input logic [7:0] v, input logic [2:0] p, input logic [4:0] m);
    return v == lim(p) - 8'd1 && (m & above(p)) == 5'd0;
  endfunction
  // the phase field of s doubles as the current-phase register
  assign phase       = bus.s[3:1];
  assign rest        = en & above(phase);
  assign at_end      = bus.sel == lim(phase) - 8'd1;
  assign final_beat  = at_end && rest == 5'd0;
  assign nxt_phase   = lowest(rest);
  assign step_phase  = at_end ? nxt_phase : phase;
  assign step_sel    = at_end ? base(nxt_phase) : bus.sel + 8'd1;
  assign first_phase = lowest(bus.phase_en);
  assign first_sel   = base(first_phase);
  assign issue       = !bus.out_valid || bus.out_ready;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      en            <= '0;
      bus.sel       <= '0;
      bus.s         <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          en       <= bus.phase_en;
          bus.busy <= 1'b1;
          if (bus.phase_en == 5'd0) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state   <= RUN;
            bus.sel <= first_sel;
            bus.s   <= {bus.job_id, first_phase, last_of(first_sel, first_phase, bus.phase_en)};
          end
        end
        RUN: if (issue) begin
          bus.out_valid <= 1'b1;
          if (final_beat) state <= DRAIN;
          else begin
            bus.sel <= step_sel;
            bus.s   <= {bus.s[7:4], step_phase, last_of(step_sel, step_phase, en)};
          end
        end
        DRAIN: if (bus.out_valid && bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.done      <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux_read_sequencer.sv
// tb_mux_read_sequencer: directed sweeps checked every cycle against a beat-list model plus literal pins
module tb_mux_read_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   accepts = 0;
  int   n;
  logic [7:0] cap_s47;
  bit   armed = 1'b0;
  mux_read_sequencer_if bus ();
  mux_read_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: expected beat list derived from the enables, walked one issue at a time
  int         q[$];
  logic [2:0] qp[$];
  int         mode = 0;
  int         pos = 0;
  logic       m_valid = 0, m_busy = 0, m_done = 0;
  logic [7:0] m_sel = 0, m_s = 0;
  logic [3:0] m_job = 0;
  task present(input int i);
    m_sel = 8'(q[i]);
    m_s   = {m_job, qp[i], i == q.size() - 1};
  endtask
  always @(posedge clock) begin
    armed = 1'b1;
    if (!reset) begin
      mode = 0; m_valid = 0; m_busy = 0; m_done = 0; m_sel = 0; m_s = 0;
    end else begin
      case (mode)
        0: if (bus.start) begin
          q.delete(); qp.delete();
          for (int p = 0; p < 5; p++)
            if (bus.phase_en[p])
              for (int k = (p == 0 ? 0 : 8 * p + 8); k < 8 * p + 16; k++) begin
                q.push_back(k);
                qp.push_back(3'(p));
              end
          m_job  = bus.job_id;
          m_busy = 1;
          if (q.size() == 0) begin mode = 3; m_done = 1; end
          else begin mode = 1; pos = 0; present(0); end
        end
        1: if (!m_valid || bus.out_ready) begin
          m_valid = 1;
          if (pos == q.size() - 1) mode = 2;
          else begin pos++; present(pos); end
        end
        2: if (m_valid && bus.out_ready) begin m_valid = 0; m_done = 1; mode = 3; end
        default: begin m_done = 0; m_busy = 0; mode = 0; end
      endcase
    end
  end
  always @(negedge clock) if (armed) begin
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("s", 32'(bus.s), 32'(m_s));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    if (reset && bus.out_valid && bus.out_ready) accepts++;
    if (bus.sel == 8'd47) cap_s47 = bus.s;
  end
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic do_start(input logic [4:0] en, input logic [3:0] job);
    accepts = 0;
    cap_s47 = 8'h00;
    bus.start = 1'b1; bus.phase_en = en; bus.job_id = job;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int cnt);
    cnt = 0;
    do begin @(negedge clock); cnt++; end while (!bus.done && cnt < budget);
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask
  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.phase_en = '0; bus.job_id = '0; bus.out_ready = 1'b1;
    tick(); tick();
    @(negedge clock);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #1 reset = 1'b1;
    tick();
    // full sweep at full throughput
    do_start(5'h1F, 4'h3);
    @(negedge clock);
    chk("full_first_s", 32'(bus.s), 32'h30);
    chk("full_first_valid", 32'(bus.out_valid), 32'd0);
    wait_done(80, n);
    chk("full_done_cycle", 32'(n + 1), 32'd50);
    chk("full_accepts", 32'(accepts), 32'd48);
    chk("full_last_s", 32'(cap_s47), 32'h39);
    // a start presented during the done cycle is dropped
    #1 bus.start = 1'b1; bus.phase_en = 5'h1F; bus.job_id = 4'h6;
    tick();
    bus.start = 1'b0;
    @(negedge clock);
    chk("start_in_done_busy", 32'(bus.busy), 32'd0);
    tick();
    // A and C only
    do_start(5'b10100, 4'h5);
    @(negedge clock);
    chk("ac_first_s", 32'(bus.s), 32'h54);
    chk("ac_first_sel", 32'(bus.sel), 32'd24);
    wait_done(60, n);
    chk("ac_done_cycle", 32'(n + 1), 32'd18);
    chk("ac_accepts", 32'(accepts), 32'd16);
    chk("ac_last_s", 32'(cap_s47), 32'h59);
    tick();
    // backpressure on the columns-only sweep while sel=20
    do_start(5'b00010, 4'h2);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("stall_sel", 32'(bus.sel), 32'd20);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_done(60, n);
    chk("stall_accepts", 32'(accepts), 32'd8);
    chk("stall_final_sel", 32'(bus.sel), 32'd23);
    tick();
    // no phases enabled
    do_start(5'd0, 4'h1);
    @(negedge clock);
    chk("empty_done", 32'(bus.done), 32'd1);
    chk("empty_busy", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clock);
    chk("empty_busy_after", 32'(bus.busy), 32'd0);
    chk("empty_accepts", 32'(accepts), 32'd0);
    tick();
    // reset at beat 10, then a fresh B-only sweep
    do_start(5'h1F, 4'h9);
    repeat (10) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_sel", 32'(bus.sel), 32'd0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    tick();
    do_start(5'b01000, 4'h4);
    @(negedge clock);
    chk("b_first_s", 32'(bus.s), 32'h46);
    chk("b_first_sel", 32'(bus.sel), 32'd32);
    wait_done(60, n);
    chk("b_done_cycle", 32'(n + 1), 32'd10);
    chk("b_accepts", 32'(accepts), 32'd8);
    tick();
    // start while busy is ignored
    do_start(5'h1F, 4'h3);
    repeat (5) tick();
    bus.start = 1'b1; bus.job_id = 4'h7; bus.phase_en = 5'h01;
    tick();
    bus.start = 1'b0;
    @(negedge clock);
    chk("busy_start_job", 32'(bus.s[7:4]), 32'h3);
    wait_done(80, n);
    chk("busy_start_accepts", 32'(accepts), 32'd48);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
